// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants and types for the rotary-switch display
//             readback decoder: glyph patterns (active-high, {A..G,Dp}),
//             matching switch codes, result class, controller state and the
//             glyph decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Lit-segment patterns P = ~SEG, bit order {A,B,C,D,E,F,G,Dp}
   localparam logic [7:0] c_GLYPH_0 = 8'b1111_1100;
   localparam logic [7:0] c_GLYPH_5 = 8'b1011_0110;
   localparam logic [7:0] c_GLYPH_A = 8'b1110_1110;
   localparam logic [7:0] c_GLYPH_F = 8'b1000_1110;
   localparam logic [7:0] c_BLANK   = 8'b0000_0000;

   localparam logic [3:0] c_CODE_0  = 4'h0;
   localparam logic [3:0] c_CODE_5  = 4'h5;
   localparam logic [3:0] c_CODE_A  = 4'hA;
   localparam logic [3:0] c_CODE_F  = 4'hF;

   typedef enum logic [1:0] {
      CLS_BLANK   = 2'd0,
      CLS_LEGAL   = 2'd1,
      CLS_ILLEGAL = 2'd2
   } seg7_class_e;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } seg7_state_e;

   // Result used for change detection. The code field is forced to zero for
   // non-legal classes so that e.g. two different illegal patterns compare
   // equal.
   typedef struct packed {
      seg7_class_e cls;
      logic [3:0]  code;
   } seg7_result_t;

   function automatic seg7_result_t seg7_decode(input logic [7:0] p);
      seg7_result_t r;
      r.cls  = CLS_ILLEGAL;
      r.code = 4'h0;
      case (p)
         c_GLYPH_0: begin r.cls = CLS_LEGAL; r.code = c_CODE_0; end
         c_GLYPH_5: begin r.cls = CLS_LEGAL; r.code = c_CODE_5; end
         c_GLYPH_A: begin r.cls = CLS_LEGAL; r.code = c_CODE_A; end
         c_GLYPH_F: begin r.cls = CLS_LEGAL; r.code = c_CODE_F; end
         c_BLANK:   begin r.cls = CLS_BLANK; end
         default:   begin r.cls = CLS_ILLEGAL; end
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_stable_filter.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_stable_filter
//  Purpose  : Two-flop synchroniser on the raw segment bus followed by a
//             candidate/counter stability filter. Emits the synchronised
//             pattern and a one-cycle accept strobe in the cycle the counter
//             reaches STABLE_CYCLES.
//  Ports    : clk_i      - system clock (rising edge)
//             rst_n_i    - synchronous active-low reset
//             seg_i      - raw active-low segment lines, asynchronous
//             pattern_o  - synchronised segment value being accepted
//             accept_o   - one-cycle strobe, combinational, valid for the
//                          edge on which the count reaches STABLE_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_stable_filter
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] seg_i,
   output logic [7:0] pattern_o,
   output logic       accept_o
);

   localparam logic [7:0] c_TARGET = 8'(STABLE_CYCLES);
   localparam logic [1:0] c_WARM   = 2'd2;

   logic [7:0] sync1_q, sync2_q;
   logic [7:0] cand_q, cand_d;
   logic [7:0] cnt_q,  cnt_d;
   logic [1:0] warm_q, warm_d;
   logic       load;

   // The synchroniser resets to all-off. Its reset contents are not a real
   // sample, so the filter ignores the first two cycles after reset while
   // the flops reload from the bus.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      warm_d   = warm_q;
      load     = 1'b0;
      accept_o = 1'b0;
      if (warm_q != c_WARM) begin
         warm_d = warm_q + 2'd1;
      end else begin
         // cnt_q == 0 means no candidate captured yet
         if (cnt_q == 8'd0 || sync2_q != cand_q) begin
            load   = 1'b1;
            cand_d = sync2_q;
            cnt_d  = 8'd1;
         end else if (cnt_q != c_TARGET) begin
            cnt_d = cnt_q + 8'd1;
         end
         // Fire once per stable period; 'load' covers STABLE_CYCLES == 1
         accept_o = (cnt_d == c_TARGET) && (load || cnt_q != c_TARGET);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q <= 8'hFF;
         sync2_q <= 8'hFF;
         cand_q  <= 8'h00;
         cnt_q   <= 8'd0;
         warm_q  <= 2'd0;
      end else begin
         sync1_q <= seg_i;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         warm_q  <= warm_d;
      end
   end

   assign pattern_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/seg7_rot_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_rot_decode
//  Purpose  : Display-loopback decoder. Recovers the 4-bit rotary position
//             from the active-low segment bus, reports accepted changes via
//             an EVT/ACK handshake, flags overruns and illegal glyphs.
//  Ports    : clk_i    - system clock (rising edge)
//             rst_n_i  - synchronous active-low reset
//             seg_i    - raw segment lines {A..G,Dp}, active-low, async
//             ack_i    - consumer acknowledge for evt_o
//             code_o   - last accepted switch code
//             valid_o  - last accepted pattern was a legal glyph
//             evt_o    - accepted change pending acknowledge
//             ovr_o    - sticky: change accepted while evt_o pending
//             err_o    - one-cycle pulse on illegal pattern acceptance
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_rot_decode
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] seg_i,
   input  logic       ack_i,
   output logic [3:0] code_o,
   output logic       valid_o,
   output logic       evt_o,
   output logic       ovr_o,
   output logic       err_o
);

   logic [7:0]   pattern;
   logic         accept;
   seg7_result_t res;
   logic         change;

   seg7_state_e  state_q, state_d;
   seg7_result_t last_q,  last_d;
   logic [3:0]   code_q,  code_d;
   logic         valid_q, valid_d;
   logic         evt_q,   evt_d;
   logic         ovr_q,   ovr_d;
   logic         err_q,   err_d;

   seg7_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .seg_i     (seg_i),
      .pattern_o (pattern),
      .accept_o  (accept)
   );

   assign res = seg7_decode(~pattern);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      code_d  = code_q;
      valid_d = valid_q;
      evt_d   = evt_q;
      ovr_d   = ovr_q;
      err_d   = 1'b0;

      // The very first acceptance after reset is always reported.
      change = accept && ((state_q == ST_INIT) || (res != last_q));

      if (evt_q && ack_i) begin
         evt_d = 1'b0;
      end

      if (accept) begin
         state_d = ST_TRACK;
         last_d  = res;
         valid_d = (res.cls == CLS_LEGAL);
         err_d   = (res.cls == CLS_ILLEGAL);
         if (res.cls == CLS_LEGAL) begin
            code_d = res.code;
         end
         if (change) begin
            // A simultaneous ACK consumes the old event, so no overrun.
            if (evt_q && !ack_i) begin
               ovr_d = 1'b1;
            end
            evt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_INIT;
         last_q  <= '{cls: CLS_BLANK, code: 4'h0};
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         evt_q   <= 1'b0;
         ovr_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         evt_q   <= evt_d;
         ovr_q   <= ovr_d;
         err_q   <= err_d;
      end
   end

   assign code_o  = code_q;
   assign valid_o = valid_q;
   assign evt_o   = evt_q;
   assign ovr_o   = ovr_q;
   assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_rot_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_rot_decode
//  Purpose  : Self-checking bench. Stimulus pushes each expected output
//             vector {code,valid,evt,ovr,err} into a queue; a monitor pops
//             and compares whenever the observed output vector changes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_rot_decode;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ack;
   logic [7:0] seg;
   logic [3:0] code;
   logic       valid, evt, ovr, err;
   logic [7:0] obs;

   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         mon_en   = 1'b0;

   // Raw (active-low) bus values, hand-inverted from the glyph patterns
   localparam logic [7:0] SEG_G0  = 8'b0000_0011; // P = 1111_1100
   localparam logic [7:0] SEG_G5  = 8'b0100_1001; // P = 1011_0110
   localparam logic [7:0] SEG_GA  = 8'b0001_0001; // P = 1110_1110
   localparam logic [7:0] SEG_GF  = 8'b0111_0001; // P = 1000_1110
   localparam logic [7:0] SEG_DP  = 8'b0000_0010; // P = 1111_1101, Dp lit
   localparam logic [7:0] SEG_ALL = 8'b0000_0000; // P = 1111_1111, illegal
   localparam logic [7:0] SEG_OFF = 8'b1111_1111; // blank

   always #5 clk = ~clk;

   seg7_rot_decode #(
      .STABLE_CYCLES (4)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .seg_i   (seg),
      .ack_i   (ack),
      .code_o  (code),
      .valid_o (valid),
      .evt_o   (evt),
      .ovr_o   (ovr),
      .err_o   (err)
   );

   assign obs = {code, valid, evt, ovr, err};

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   // Scoreboard monitor: every change of the output vector must match the
   // next expected vector.
   initial begin
      logic [7:0] prev;
      logic [7:0] e;
      prev = 8'h00;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (obs !== prev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_change: got %h required %h (no change) t=%0t",
                        obs, prev, $time);
            end else begin
               e = exp_q.pop_front();
               check("scoreboard", obs, e);
            end
            prev = obs;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      ack   = 1'b0;
      seg   = SEG_OFF;
      tick(3);
      check("reset_code",  {4'h0, code}, 8'h00);
      check("reset_valid", {7'h0, valid}, 8'h00);
      check("reset_evt",   {7'h0, evt},   8'h00);
      check("reset_ovr",   {7'h0, ovr},   8'h00);
      check("reset_err",   {7'h0, err},   8'h00);

      // ---- 1: first legal glyph, latency and ACK ----
      seg = SEG_GA;
      exp_q.push_back(8'hAC);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick(5);
      check("latency_pre_evt", {7'h0, evt}, 8'h00);
      tick(1);
      check("latency_code", {4'h0, code}, 8'h0A);
      check("latency_evt",  {7'h0, evt},  8'h01);
      exp_q.push_back(8'hA8);
      ack_pulse();
      tick(2);

      // ---- 2: glyph 0, stray ACK, glitch, glyph 5 ----
      exp_q.push_back(8'h0C);
      seg = SEG_G0;
      tick(8);
      exp_q.push_back(8'h08);
      ack_pulse();
      tick(2);
      ack_pulse();            // EVT low: must be ignored
      tick(1);
      seg = SEG_ALL;          // 2-cycle glitch
      tick(2);
      exp_q.push_back(8'h5C);
      seg = SEG_G5;
      tick(8);
      exp_q.push_back(8'h58);
      ack_pulse();
      tick(2);

      // ---- 3: Dp lit, then a different illegal pattern (no change) ----
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h54);
      seg = SEG_DP;
      tick(10);
      exp_q.push_back(8'h50);
      ack_pulse();
      tick(2);
      exp_q.push_back(8'h51);
      exp_q.push_back(8'h50);
      seg = SEG_ALL;
      tick(10);

      // ---- 4: overrun ----
      exp_q.push_back(8'hFC);
      seg = SEG_GF;
      tick(8);
      exp_q.push_back(8'h0E);
      seg = SEG_G0;
      tick(8);
      check("ovr_set", {7'h0, ovr}, 8'h01);
      exp_q.push_back(8'h0A);
      ack_pulse();
      tick(3);
      check("ovr_sticky", {7'h0, ovr}, 8'h01);

      // ---- 5: acceptance coincident with ACK ----
      exp_q.push_back(8'h00);
      rst_n = 1'b0;
      seg   = SEG_GA;
      tick(2);
      exp_q.push_back(8'hAC);
      rst_n = 1'b1;
      tick(8);
      exp_q.push_back(8'h5C);
      seg = SEG_G5;
      tick(5);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("coincide_evt",  {7'h0, evt},  8'h01);
      check("coincide_ovr",  {7'h0, ovr},  8'h00);
      check("coincide_code", {4'h0, code}, 8'h05);
      exp_q.push_back(8'h58);
      ack_pulse();
      tick(2);

      // ---- 6: reset mid-count, blank accepted in INIT ----
      seg = SEG_GF;
      tick(2);
      exp_q.push_back(8'h00);
      rst_n = 1'b0;
      seg   = SEG_OFF;
      tick(1);
      exp_q.push_back(8'h04);
      rst_n = 1'b1;
      tick(5);
      check("blank_pre_evt", {7'h0, evt}, 8'h00);
      tick(1);
      check("blank_evt",   {7'h0, evt},   8'h01);
      check("blank_valid", {7'h0, valid}, 8'h00);
      exp_q.push_back(8'h00);
      ack_pulse();
      tick(3);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
